// File: rtl/instr_line_mem.sv
// rtl/instr_line_mem.sv - instruction line memory with fill-on-init and line-wide registered reads
module instr_line_mem #(
  parameter int               WORD_W    = 32,
  parameter int               DEPTH     = 16,
  parameter int               BUS_W     = 256,
  parameter logic [3:0]       SELECT    = 4'h1,
  parameter logic [WORD_W-1:0] FILL_WORD = WORD_W'(32'hFF000000)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [15:0]      address,
  input  logic             nRead,
  input  logic             nWrite,
  input  logic [BUS_W-1:0] DataIn,
  output logic [BUS_W-1:0] DataOut,
  output logic             DataValid,
  output logic             AddrErr,
  output logic             Busy
);

  localparam int         LINE    = BUS_W / WORD_W;
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [12:0] DEPTH_L = 13'(DEPTH);

  typedef enum logic {INIT, IDLE} state_t;

  state_t            state, state_next;
  logic [AW-1:0]     cnt;
  logic [WORD_W-1:0] mem [DEPTH];

  logic [11:0]       idx;
  logic              in_range;
  logic              sel, wr, rd;
  logic [BUS_W-1:0]  line_next;

  assign idx      = address[11:0];
  assign in_range = ({1'b0, idx} < DEPTH_L);
  // Requests only count once init is done and the block is addressed; write beats read.
  assign sel      = (state == IDLE) && (address[15:12] == SELECT);
  assign wr       = sel && !nWrite;
  assign rd       = sel && nWrite && !nRead;

  // Only the low word of the write bus is stored.
  if (BUS_W > WORD_W) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^DataIn[BUS_W-1:WORD_W];
  end

  // State register and init word counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) cnt <= cnt + 1'b1;
      else               cnt <= '0;
    end
  end

  // Next state: INIT walks every word once, then stays in IDLE until reset.
  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    case (state)
      INIT: begin
        Busy = 1'b1;
        if (cnt == AW'(DEPTH - 1)) state_next = IDLE;
      end
      IDLE:    state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  // Memory array: filled with the STOP word during init, then written by selected in-range writes.
  always_ff @(posedge Clk) begin
    if (state == INIT)
      mem[cnt] <= FILL_WORD;
    else if (wr && in_range)
      mem[idx[AW-1:0]] <= DataIn[WORD_W-1:0];
  end

  // Assemble the line starting at idx; words past the end read as the fill word, never wrapping.
  always_comb begin
    line_next = '0;
    for (int k = 0; k < LINE; k++) begin
      if (({1'b0, idx} + 13'(k)) < DEPTH_L)
        line_next[k*WORD_W +: WORD_W] = mem[AW'({1'b0, idx} + 13'(k))];
      else
        line_next[k*WORD_W +: WORD_W] = FILL_WORD;
    end
  end

  // Registered response: line and pulses appear one cycle after the request.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DataOut   <= '0;
      DataValid <= 1'b0;
      AddrErr   <= 1'b0;
    end else begin
      DataValid <= rd;
      AddrErr   <= (rd || wr) && !in_range;
      if (rd) DataOut <= line_next;
    end
  end

endmodule
